lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit between the datapath and a 32-bit word-addressed data memory bus. It takes one memory access per handshake, using the control decoder's MemRW/MemCtr/Memsel encodings. It drives aligned bus transactions with byte enables, and splits misaligned halfword/word accesses into two transactions. It returns sign- or zero-extended load data to the writeback mux.

## Interface
- `ADDR_W`, default 32: byte address width.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: core request valid.
- `req_ready`  out  1: block can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, LSB-justified.
- `req_memrw`  in  1: 1 = store, 0 = load.
- `req_memctr`  in  2: store width; 00 SB, 01 SH, 10 SW.
- `req_memsel`  in  3: load type; 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU.
- `rsp_valid`  out  1: one-cycle pulse, access complete.
- `rsp_rdata`  out  32: extended load data; 0 for stores.
- `bus_req`  out  1: bus transaction request.
- `bus_gnt`  in  1: bus accepts the request this cycle.
- `bus_addr`  out  ADDR_W: word-aligned address; bits [1:0] = 0.
- `bus_we`  out  1: write enable.
- `bus_be`  out  4: byte enables.
- `bus_wdata`  out  32: lane-aligned write data.
- `bus_rvalid`  in  1: response/ack for the oldest granted transaction.
- `bus_rdata`  in  32: read data, valid with bus_rvalid.

## Operation
- Size: 1, 2 or 4 bytes, taken from memctr (stores) or memsel (loads).
- Illegal codes are treated as word: memctr 11, and memsel 101–111.
- `off` = addr[1:0]. An access is split when off + size > 4: word with off≠0, or half with off=3.
- Byte-enable vector: be8 = ((1<<size)-1) << off. Data vector: wd64 = wdata << (8·off).
  - First transaction: word addr[ADDR_W-1:2], be = be8[3:0], wdata = wd64[31:0].
  - Second transaction: word address + 1, wrapping modulo 2^ADDR_W; be = be8[7:4], wdata = wd64[63:32].
- Load result:
  - Build a 64-bit vector {rdata1, rdata0}; rdata1 = 0 when the access is not split.
  - Shift it right by 8·off and truncate to size.
  - Extend per memsel: LH/LB sign-extend; LHU/LBU/LW zero-extend.
- The request is captured in registers at accept (req_valid & req_ready). Request inputs are ignored at all other times.
- FSM states:
  - IDLE → REQ0 on accept.
  - REQ0: bus_req=1 with first-transaction fields; → WAIT0 on bus_gnt.
  - WAIT0: on bus_rvalid, latch rdata0; → REQ1 if split, else DONE.
  - REQ1: second-transaction fields; → WAIT1 on bus_gnt.
  - WAIT1: on bus_rvalid, latch rdata1; → DONE.
  - DONE: rsp_valid=1 and rsp_rdata valid; → IDLE.
- Stores also wait for bus_rvalid as the write ack. rsp_rdata = 0 for stores.
- bus_rvalid is ignored in IDLE, REQ0, REQ1 and DONE.
- Bus-side outputs are stable while bus_req=1 and bus_gnt=0.

## Timing
- All outputs are registered or decoded from state and capture registers. There is no combinational path from req_* to bus_*.
- Reset values, while rst_n=0 and after release: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0; bus_req=0, bus_addr=0, bus_we=0, bus_be=0, bus_wdata=0.
- Non-split access, gnt in its first cycle, rvalid the cycle after gnt: accept at cycle T; bus_req at T+1; rvalid at T+2; rsp_valid at T+3. Latency is 3 cycles.
- Split access adds 2 cycles minimum, giving latency 5.
- Back-to-back: req_ready is high again the cycle after DONE, so the minimum period is 4 cycles per non-split access.
- Reset asserted mid-operation: everything returns to IDLE immediately. No rsp_valid is produced for the aborted access. A late bus_rvalid after reset is ignored.
- bus_gnt and bus_rvalid asserted in the same cycle in REQ0 or REQ1: rvalid is ignored, because the bus does not return data in the grant cycle.

## Structure
- Package `lsu_pkg` holds:
  - memctr constants SB/SH/SW and memsel constants LW/LH/LB/LHU/LBU, matching the decoder encodings;
  - the FSM state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE);
  - a size-decode function.
- Sub-module `lsu_load_align` (combinational): inputs rdata0, rdata1, off, memsel; output the extended 32-bit result.
- The top level holds the FSM, the capture registers and the byte-enable/write-data generation.

## Test plan
- Aligned LW at 0x100; memory returns 0xDEADBEEF. Expect one transaction (bus_addr 0x100, be 1111), rsp_rdata 0xDEADBEEF, rsp_valid at T+3.
- LB at 0x203, byte = 0x80. Expect be 1000 and rsp_rdata 0xFFFFFF80. Repeat as LBU: expect 0x00000080.
- SH at 0x107, wdata 0x0000ABCD. Expect two transactions:
  - 0x104, be 1000, bus_wdata 0xCD000000;
  - 0x108, be 0001, bus_wdata 0x000000AB.
  - rsp_valid after the second ack.
- LW at 0xFFFFFFFE, words {0x11223344 @0xFFFFFFFC, 0x55667788 @0x0}. Expect the second bus_addr to wrap to 0x0 and rsp_rdata 0x77881122.
- bus_gnt held low for 5 cycles in REQ0. Expect bus_req, bus_addr, bus_be and bus_wdata stable throughout and req_ready=0.
- Assert rst_n low in WAIT0 of a split load. Expect all outputs at reset values immediately, no rsp_valid, and a stale bus_rvalid after release ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and access-size decode for the load/store unit
package lsu_pkg;

  localparam logic [1:0] MEMCTR_SB = 2'b00;
  localparam logic [1:0] MEMCTR_SH = 2'b01;
  localparam logic [1:0] MEMCTR_SW = 2'b10;

  localparam logic [2:0] MEMSEL_LW  = 3'b000;
  localparam logic [2:0] MEMSEL_LH  = 3'b001;
  localparam logic [2:0] MEMSEL_LB  = 3'b010;
  localparam logic [2:0] MEMSEL_LHU = 3'b011;
  localparam logic [2:0] MEMSEL_LBU = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    DONE
  } lsu_state_e;

  // Access size in bytes; unknown codes fall back to a full word.
  function automatic logic [2:0] access_size(input logic       memrw,
                                             input logic [1:0] memctr,
                                             input logic [2:0] memsel);
    logic [2:0] sz;
    sz = 3'd4;
    if (memrw) begin
      if (memctr == MEMCTR_SB)      sz = 3'd1;
      else if (memctr == MEMCTR_SH) sz = 3'd2;
    end else begin
      case (memsel)
        MEMSEL_LH, MEMSEL_LHU: sz = 3'd2;
        MEMSEL_LB, MEMSEL_LBU: sz = 3'd1;
        default:               sz = 3'd4;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts the two-word read window down by the byte offset and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  input  logic [1:0]  off,
  input  logic [2:0]  memsel,
  output logic [31:0] rdata
);

  logic [31:0] win;

  always_comb begin
    win = 32'({rdata1, rdata0} >> {off, 3'b000});
    case (memsel)
      MEMSEL_LH:  rdata = {{16{win[15]}}, win[15:0]};
      MEMSEL_LB:  rdata = {{24{win[7]}}, win[7:0]};
      MEMSEL_LHU: rdata = {16'd0, win[15:0]};
      MEMSEL_LBU: rdata = {24'd0, win[7:0]};
      default:    rdata = win;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit: captures one access, issues one or two aligned bus transactions
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_memrw,
  input  logic [1:0]        req_memctr,
  input  logic [2:0]        req_memsel,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              memrw_q;
  logic [1:0]        memctr_q;
  logic [2:0]        memsel_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic [2:0]        size;
  logic [1:0]        off;
  logic              split;
  logic [7:0]        mask;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [ADDR_W-3:0] word0, word1;
  logic [31:0]       load_data;

  // Everything driven onto the bus derives from the capture registers only.
  always_comb begin
    size  = access_size(memrw_q, memctr_q, memsel_q);
    off   = addr_q[1:0];
    split = ({2'b00, off} + {1'b0, size}) > 4'd4;
    mask  = (8'd1 << size) - 8'd1;
    be8   = mask << off;
    wd64  = {32'd0, wdata_q} << {off, 3'b000};
    word0 = addr_q[ADDR_W-1:2];
    word1 = word0 + (ADDR_W-2)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      memrw_q  <= 1'b0;
      memctr_q <= '0;
      memsel_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        memrw_q  <= req_memrw;
        memctr_q <= req_memctr;
        memsel_q <= req_memsel;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state_q == WAIT0 && bus_rvalid) rdata0_q <= bus_rdata;
      if (state_q == WAIT1 && bus_rvalid) rdata1_q <= bus_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_req   = 1'b0;
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_be    = 4'd0;
    bus_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = REQ0;
      end
      REQ0: begin
        bus_req   = 1'b1;
        bus_addr  = {word0, 2'b00};
        bus_we    = memrw_q;
        bus_be    = be8[3:0];
        bus_wdata = wd64[31:0];
        if (bus_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (bus_rvalid) state_d = split ? REQ1 : DONE;
      end
      REQ1: begin
        bus_req   = 1'b1;
        bus_addr  = {word1, 2'b00};
        bus_we    = memrw_q;
        bus_be    = be8[7:4];
        bus_wdata = wd64[63:32];
        if (bus_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus_rvalid) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata0 (rdata0_q),
    .rdata1 (rdata1_q),
    .off    (off),
    .memsel (memsel_q),
    .rdata  (load_data)
  );

  assign rsp_rdata = (state_q == DONE && !memrw_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench with byte-level reference memory and a randomized bus responder
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_memrw;
  logic [1:0]  req_memctr;
  logic [2:0]  req_memsel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_memrw(req_memrw), .req_memctr(req_memctr),
    .req_memsel(req_memsel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} txn_t;
  typedef struct {logic [31:0] rdata; int lat; int t0;} rsp_t;

  txn_t        exp_txn[$];
  rsp_t        exp_rsp[$];
  logic [31:0] bus_mem[logic [29:0]];
  logic [31:0] ref_mem[logic [29:0]];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        fast, force_stall, hold_rsp;
  int          stale_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] w);
    return bus_mem.exists(w) ? bus_mem[w] : init_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic ref_wr_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    w[{a[1:0], 3'b000} +: 8] = b;
    ref_mem[a[31:2]] = w;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    bus_mem[a[31:2]] = v;
    ref_mem[a[31:2]] = v;
  endtask

  function automatic int size_of(input logic rw, input logic [1:0] ctr, input logic [2:0] sel);
    if (rw) return (ctr == 2'b00) ? 1 : (ctr == 2'b01) ? 2 : 4;
    case (sel)
      3'b001, 3'b011: return 2;
      3'b010, 3'b100: return 1;
      default:        return 4;
    endcase
  endfunction

  // Waits for req_ready, records the expected bus traffic and response, then presents the request.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                       input logic [1:0] ctr, input logic [2:0] sel, input int lat);
    int          sz, off, n;
    logic [63:0] be8, wd64;
    logic [31:0] val;
    txn_t        t;
    rsp_t        r;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    sz   = size_of(rw, ctr, sel);
    off  = int'(addr[1:0]);
    be8  = ((64'd1 << sz) - 64'd1) << off;
    wd64 = {32'd0, wdata} << (8 * off);
    t.addr = {addr[31:2], 2'b00}; t.we = rw; t.be = be8[3:0]; t.wdata = wd64[31:0];
    exp_txn.push_back(t);
    if (off + sz > 4) begin
      t.addr = t.addr + 32'd4; t.be = be8[7:4]; t.wdata = wd64[63:32];
      exp_txn.push_back(t);
    end
    val = 32'd0;
    for (int i = 0; i < sz; i++) begin
      if (rw) ref_wr_byte(addr + 32'(i), wdata[8*i +: 8]);
      else    val = val | ({24'd0, ref_byte(addr + 32'(i))} << (8 * i));
    end
    if (!rw && sel == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
    if (!rw && sel == 3'b010 && val[7])  val = val | 32'hFFFF_FF00;
    r.rdata = val; r.lat = lat; r.t0 = cyc;
    exp_rsp.push_back(r);
    req_addr = addr; req_wdata = wdata; req_memrw = rw; req_memctr = ctr; req_memsel = sel;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_memrw  = 1'($urandom);
    req_memctr = 2'($urandom);
    req_memsel = 3'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("completion_timeout", 32'd0, 32'd1);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_rsp.size() == 0) chk("spurious_rsp_valid", 32'd1, 32'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.t0), 32'(r.lat));
        end
      end
    end
  end

  // Bus responder with its own memory; checks each granted transaction and stall stability.
  initial begin : bus_model
    logic        outstanding, responding, gave_gnt, stalled;
    int          dly, stale_done;
    logic [31:0] rsp_word, s_addr, s_wdata, w;
    logic [3:0]  s_be;
    logic        s_we;
    txn_t        t;
    outstanding = 0; responding = 0; gave_gnt = 0; stalled = 0; dly = 0; stale_done = 0;
    rsp_word = 0; s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0; responding = 0; gave_gnt = 0; stalled = 0;
        bus_gnt = 0; bus_rvalid = 0;
        continue;
      end
      if (responding) begin
        outstanding = 0;
        responding  = 0;
      end
      if (gave_gnt) begin
        outstanding = 1;
        dly = fast ? 0 : int'($urandom_range(0, 2));
      end
      bus_gnt = 0; bus_rvalid = 0; gave_gnt = 0;
      if (stale_cnt != stale_done) begin
        stale_done++;
        bus_rvalid = 1;
        bus_rdata  = $urandom;
      end else if (outstanding && !hold_rsp) begin
        if (dly == 0) begin
          bus_rvalid = 1;
          bus_rdata  = rsp_word;
          responding = 1;
        end else dly--;
      end
      if (bus_req) begin
        if (stalled) begin
          chk("stall_bus_addr", bus_addr, s_addr);
          chk("stall_bus_be", 32'(bus_be), 32'(s_be));
          chk("stall_bus_we", 32'(bus_we), 32'(s_we));
          chk("stall_bus_wdata", bus_wdata, s_wdata);
        end
        if (!force_stall && (fast || $urandom_range(0, 2) == 0)) begin
          bus_gnt = 1; gave_gnt = 1; stalled = 0;
          if (exp_txn.size() == 0) chk("unexpected_bus_txn", 32'd1, 32'd0);
          else begin
            t = exp_txn.pop_front();
            chk("bus_addr", bus_addr, t.addr);
            chk("bus_we", 32'(bus_we), 32'(t.we));
            chk("bus_be", 32'(bus_be), 32'(t.be));
            if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
          end
          if (bus_we) begin
            w = bus_rd(bus_addr[31:2]);
            for (int b = 0; b < 4; b++) if (bus_be[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
            bus_mem[bus_addr[31:2]] = w;
            rsp_word = $urandom;
          end else rsp_word = bus_rd(bus_addr[31:2]);
          if (!fast && !bus_rvalid && $urandom_range(0, 3) == 0) begin
            bus_rvalid = 1;
            bus_rdata  = $urandom;
          end
        end else begin
          stalled = 1; s_addr = bus_addr; s_be = bus_be; s_we = bus_we; s_wdata = bus_wdata;
        end
      end else stalled = 0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_bus_be"}, 32'(bus_be), 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
  endtask

  initial begin : stimulus
    bit          seen;
    int          n;
    logic [31:0] a;
    rst_n = 0; req_valid = 0; req_addr = 0; req_wdata = 0;
    req_memrw = 0; req_memctr = 0; req_memsel = 0;
    fast = 1; force_stall = 0; hold_rsp = 0; stale_cnt = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("in_reset");
    #2 rst_n = 1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    preload(32'h0000_0100, 32'hDEAD_BEEF);
    preload(32'h0000_0200, 32'h8012_3456);
    preload(32'hFFFF_FFFC, 32'h1122_3344);
    preload(32'h0000_0000, 32'h5566_7788);

    issue(32'h0000_0100, 32'h0, 1'b0, 2'b00, 3'b000, 3);
    issue(32'h0000_0203, 32'h0, 1'b0, 2'b00, 3'b010, 3);
    issue(32'h0000_0203, 32'h0, 1'b0, 2'b00, 3'b100, 3);
    issue(32'h0000_0107, 32'h0000_ABCD, 1'b1, 2'b01, 3'b000, 5);
    issue(32'hFFFF_FFFE, 32'h0, 1'b0, 2'b00, 3'b000, 5);
    issue(32'h0000_0106, 32'h0, 1'b0, 2'b00, 3'b001, 3);
    wait_done();

    force_stall = 1;
    issue(32'h0000_0102, 32'h0, 1'b0, 2'b00, 3'b011, -1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_bus_req", 32'(bus_req), 32'd1);
    end
    force_stall = 0;
    wait_done();

    hold_rsp = 1;
    issue(32'h0000_0102, 32'h0, 1'b0, 2'b00, 3'b000, -1);
    seen = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus_req) seen = 1;
      else if (seen) break;
      n++;
    end
    chk("reached_wait0", 32'(seen && !bus_req && !req_ready), 32'd1);
    #2 rst_n = 0;
    #1 chk_reset_outputs("mid_reset");
    exp_rsp.delete();
    exp_txn.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    hold_rsp = 0;
    stale_cnt = stale_cnt + 1;
    repeat (4) @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    chk("post_reset_bus_req", 32'(bus_req), 32'd0);
    issue(32'h0000_0100, 32'h0, 1'b0, 2'b00, 3'b000, 3);
    wait_done();

    fast = 0;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = ($urandom_range(0, 1) == 1 ? 32'h0000_0100 : 32'hFFFF_FFE0) + 32'($urandom_range(0, 31));
      issue(a, $urandom, 1'($urandom), 2'($urandom), 3'($urandom), -1);
    end
    wait_done();
    chk("leftover_bus_txns", 32'(exp_txn.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
